// File: rtl/fpu_mac_dma_sequencer.sv
// Avalon-MM sequencer: streams vectors A/B from memory into the FPU MAC slave, runs it and stores the dot product.
// Optional bus-stall watchdog is compiled in with FPU_SEQ_TIMEOUT_EN.
module fpu_mac_dma_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  csr_address,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        irq
);
    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_CLR, S_RDA, S_WRA, S_RDB, S_WRB, S_CNT, S_GO, S_RES, S_STR, S_FIN
    } state_t;

    localparam logic [31:0] K_B    = 32'(MAX_LEN);
    localparam logic [31:0] K_CTRL = 32'(2 * MAX_LEN);

    state_t      state_q, state_d;
    logic [31:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
    logic [31:0] len_q, len_d, mac_base_q, mac_base_d;
    logic        irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
    logic [6:0]  idx_q, idx_d, idx_n;
    logic        m_read_q, m_read_d, m_write_q, m_write_d;
    logic [31:0] m_address_q, m_address_d, m_writedata_q, m_writedata_d;
`ifdef FPU_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
`endif

    logic        busy, xfer;
    logic [31:0] idx32, idx_n32;

    assign busy    = (state_q != S_IDLE);
    assign xfer    = (m_read_q | m_write_q) & ~m_waitrequest;
    assign idx_n   = idx_q + 7'd1;
    assign idx32   = {25'b0, idx_q};
    assign idx_n32 = {25'b0, idx_n};

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] k);
        return base + {k[29:0], 2'b00};
    endfunction

    always_comb begin
        state_d       = state_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        dst_d         = dst_q;
        len_d         = len_q;
        mac_base_d    = mac_base_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        err_d         = err_q;
        idx_d         = idx_q;
        m_read_d      = m_read_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;

        if (csr_write) begin
            case (csr_address)
                3'd0: if (!busy) src_a_d = csr_writedata;
                3'd1: if (!busy) src_b_d = csr_writedata;
                3'd2: if (!busy) dst_d = csr_writedata;
                3'd3: if (!busy) len_d = csr_writedata;
                3'd4: begin
                    irq_en_d = csr_writedata[1];
                    if (csr_writedata[0] && !busy) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = S_CHK;
                    end
                end
                3'd5: begin
                    if (csr_writedata[1]) done_d = 1'b0;
                    if (csr_writedata[2]) err_d = 1'b0;
                end
                3'd6: if (!busy) mac_base_d = csr_writedata;
                default: ;
            endcase
        end

        // Each state's next request is loaded on the edge its predecessor completes.
        case (state_q)
            S_IDLE: ;
            S_CHK: begin
                idx_d = '0;
                if (len_q == 32'd0 || len_q > 32'(MAX_LEN)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d       = S_CLR;
                    m_write_d     = 1'b1;
                    m_address_d   = word_addr(mac_base_q, K_CTRL);
                    m_writedata_d = 32'd0;
                end
            end
            S_CLR: if (xfer) begin
                state_d     = S_RDA;
                m_write_d   = 1'b0;
                m_read_d    = 1'b1;
                m_address_d = word_addr(src_a_q, idx32);
            end
            S_RDA: if (xfer) begin
                state_d       = S_WRA;
                m_read_d      = 1'b0;
                m_write_d     = 1'b1;
                m_address_d   = word_addr(mac_base_q, idx32);
                m_writedata_d = m_readdata;
            end
            S_WRA: if (xfer) begin
                state_d     = S_RDB;
                m_write_d   = 1'b0;
                m_read_d    = 1'b1;
                m_address_d = word_addr(src_b_q, idx32);
            end
            S_RDB: if (xfer) begin
                state_d       = S_WRB;
                m_read_d      = 1'b0;
                m_write_d     = 1'b1;
                m_address_d   = word_addr(mac_base_q, K_B + idx32);
                m_writedata_d = m_readdata;
            end
            S_WRB: if (xfer) begin
                idx_d = idx_n;
                if (idx_n32 == len_q) begin
                    state_d       = S_CNT;
                    m_address_d   = word_addr(mac_base_q, K_CTRL + 32'd1);
                    m_writedata_d = len_q;
                end else begin
                    state_d     = S_RDA;
                    m_write_d   = 1'b0;
                    m_read_d    = 1'b1;
                    m_address_d = word_addr(src_a_q, idx_n32);
                end
            end
            S_CNT: if (xfer) begin
                state_d       = S_GO;
                m_address_d   = word_addr(mac_base_q, K_CTRL + 32'd2);
                m_writedata_d = 32'd1;
            end
            S_GO: if (xfer) begin
                state_d     = S_RES;
                m_write_d   = 1'b0;
                m_read_d    = 1'b1;
                m_address_d = mac_base_q;
            end
            S_RES: if (xfer) begin
                state_d       = S_STR;
                m_read_d      = 1'b0;
                m_write_d     = 1'b1;
                m_address_d   = dst_q;
                m_writedata_d = m_readdata;
            end
            S_STR: if (xfer) begin
                state_d   = S_FIN;
                m_write_d = 1'b0;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FPU_SEQ_TIMEOUT_EN
        wd_d = '0;
        if ((m_read_q | m_write_q) && m_waitrequest) begin
            wd_d = wd_q + 1'b1;
            if (&wd_d) begin
                wd_d      = '0;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                err_d     = 1'b1;
                state_d   = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            src_a_q       <= '0;
            src_b_q       <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            mac_base_q    <= '0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            idx_q         <= '0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
`ifdef FPU_SEQ_TIMEOUT_EN
            wd_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            mac_base_q    <= mac_base_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            err_q         <= err_d;
            idx_q         <= idx_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
`ifdef FPU_SEQ_TIMEOUT_EN
            wd_q          <= wd_d;
`endif
        end
    end

    always_comb begin
        csr_readdata = 32'd0;
        if (csr_read) begin
            case (csr_address)
                3'd0: csr_readdata = src_a_q;
                3'd1: csr_readdata = src_b_q;
                3'd2: csr_readdata = dst_q;
                3'd3: csr_readdata = len_q;
                3'd4: csr_readdata = {30'b0, irq_en_q, 1'b0};
                3'd5: csr_readdata = {29'b0, err_q, done_q, busy};
                3'd6: csr_readdata = mac_base_q;
                default: csr_readdata = 32'd0;
            endcase
        end
    end

    assign m_read      = m_read_q;
    assign m_write     = m_write_q;
    assign m_address   = m_address_q;
    assign m_writedata = m_writedata_q;
    assign irq         = irq_en_q & (done_q | err_q);
endmodule

// File: tb/tb_fpu_mac_dma_sequencer.sv
// Bench for fpu_mac_dma_sequencer: memory + behavioural MAC slave, transaction scoreboard, directed jobs.
module tb_fpu_mac_dma_sequencer;
    localparam logic [31:0] SA = 32'h0000_1000;
    localparam logic [31:0] SB = 32'h0000_2000;
    localparam logic [31:0] DA = 32'h0000_3000;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic [31:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    fpu_mac_dma_sequencer dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .irq(irq)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          n_assert = 0;
    int          n_fail = 0;
    txn_t        exp_q[$];
    bit          chk_en = 0, any_req = 0, res_hold = 0, pending = 0, stalled = 0;
    int          stall_max = 0, stall_left = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] mac_a [0:63];
    logic [31:0] mac_b [0:63];
    logic [31:0] mac_cnt = '0, mac_res = '0;
    logic [31:0] p_addr, p_data, p_ctl;
    int          va [0:63];
    int          vb [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] int_to_f32(input int n);
        int p = 0;
        logic [31:0] t, u;
        u = 32'(n);
        if (n == 0) return 32'd0;
        for (int j = 0; j < 32; j++) if (u[j]) p = j;
        t = u << (23 - p);
        return {1'b0, 8'(127 + p), t[22:0]};
    endfunction

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], {3'b0, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    // Slave stall generator: one random stall length per transaction, plus an optional RES hold.
    always @(posedge clk) begin
        #1;
        if (!(m_read || m_write)) begin
            pending = 0;
            stall_left = 0;
            m_waitrequest = 1'b0;
        end else begin
            if (!pending) begin
                pending = 1;
                stall_left = $urandom_range(0, stall_max);
            end else if (stall_left > 0) begin
                stall_left--;
            end
            m_waitrequest = (stall_left > 0) || (res_hold && m_read && m_address == MB);
        end
    end

    // Slave response, scoreboard pop and stall-stability check.
    always @(negedge clk) begin
        txn_t e;
        int   k;
        real  s;
        if (reset) begin
            stalled = 0;
        end else begin
            if (stalled && (m_read || m_write)) begin
                chk("stable_addr", m_address, p_addr);
                chk("stable_data", m_writedata, p_data);
                chk("stable_ctl", {30'b0, m_read, m_write}, p_ctl);
            end
            stalled = 0;
            if (m_read || m_write) begin
                any_req = 1;
                chk("one_strobe", {31'b0, m_read & m_write}, 32'd0);
                if (m_waitrequest) begin
                    stalled = 1;
                    p_addr = m_address;
                    p_data = m_writedata;
                    p_ctl = {30'b0, m_read, m_write};
                end else begin
                    if (chk_en) begin
                        n_assert++;
                        assert (exp_q.size() != 0) else begin
                            n_fail++;
                            $error("FAIL txn_extra: observed addr %h expected no transaction", m_address);
                        end
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("txn_addr", m_address, e.addr);
                            chk("txn_dir", {31'b0, m_write}, {31'b0, e.wr});
                            if (e.wr) chk("txn_data", m_writedata, e.data);
                        end
                    end
                    if (m_address >= MB && m_address < MB + 32'h400) begin
                        k = int'((m_address - MB) >> 2);
                        if (m_write) begin
                            if (k < 64) mac_a[k] = m_writedata;
                            else if (k < 128) mac_b[k-64] = m_writedata;
                            else if (k == 128) begin
                                for (int j = 0; j < 64; j++) begin mac_a[j] = '0; mac_b[j] = '0; end
                                mac_res = '0;
                            end else if (k == 129) mac_cnt = m_writedata;
                            else if (k == 130) begin
                                s = 0.0;
                                for (int j = 0; j < 64; j++)
                                    if (j < int'(mac_cnt)) s = s + f2r(mac_a[j]) * f2r(mac_b[j]);
                                mac_res = r2f(s);
                            end
                        end else begin
                            m_readdata = (k == 0) ? mac_res : 32'd0;
                        end
                    end else if (m_write) begin
                        mem[m_address] = m_writedata;
                    end else begin
                        m_readdata = mem.exists(m_address) ? mem[m_address] : 32'hDEAD_BEEF;
                    end
                    pending = 0;
                end
            end
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk);
        #1 csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_address = a; csr_read = 1'b1;
        #1 d = csr_readdata;
        #1 csr_read = 1'b0;
    endtask

    // Loads vectors, queues the exact expected bus sequence, programs CSRs and issues START.
    task automatic start_job(input int len);
        int          dot = 0;
        logic [31:0] r;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            mem[SA + 32'(4*i)] = int_to_f32(va[i]);
            mem[SB + 32'(4*i)] = int_to_f32(vb[i]);
            dot += va[i] * vb[i];
        end
        mem[DA] = 32'd0;
        r = int_to_f32(dot);
        exp_q.push_back('{1'b1, MB + 32'd512, 32'd0});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{1'b0, SA + 32'(4*i), 32'd0});
            exp_q.push_back('{1'b1, MB + 32'(4*i), int_to_f32(va[i])});
            exp_q.push_back('{1'b0, SB + 32'(4*i), 32'd0});
            exp_q.push_back('{1'b1, MB + 32'(256 + 4*i), int_to_f32(vb[i])});
        end
        exp_q.push_back('{1'b1, MB + 32'd516, 32'(len)});
        exp_q.push_back('{1'b1, MB + 32'd520, 32'd1});
        exp_q.push_back('{1'b0, MB, 32'd0});
        exp_q.push_back('{1'b1, DA, r});
        chk_en = 1;
        csr_wr(3'd0, SA); csr_wr(3'd1, SB); csr_wr(3'd2, DA);
        csr_wr(3'd3, 32'(len)); csr_wr(3'd6, MB);
        csr_wr(3'd4, 32'd3);
    endtask

    task automatic wait_done();
        logic [31:0] st;
        int          n = 0;
        do begin
            csr_rd(3'd5, st);
            n++;
        end while (st[2:1] == 2'b00 && n < 6000);
        chk("status_done", st, 32'h2);
        chk("txn_left", 32'(exp_q.size()), 32'd0);
        chk_en = 0;
    endtask

    initial begin : main
        logic [31:0] d, r0;
        int          cyc;
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, r0;
        int          cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_read", {31'b0, m_read}, 32'd0);
        chk("rst_m_write", {31'b0, m_write}, 32'd0);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_m_writedata", m_writedata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_readdata_idle", csr_readdata, 32'd0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            csr_rd(3'(a), d);
            chk($sformatf("rst_csr%0d", a), d, 32'd0);
        end

        // LEN=1, 3.0*2.0, exact latency
        va[0] = 3; vb[0] = 2;
        start_job(1);
        cyc = 0;
        while (!irq && cyc < 100) begin @(posedge clk); cyc++; #1; end
        chk("len1_latency", 32'(cyc), 32'd11);
        wait_done();
        chk("len1_result", mem[DA], 32'h40C0_0000);
        chk("len1_irq", {31'b0, irq}, 32'd1);
        csr_wr(3'd5, 32'd2);
        csr_rd(3'd5, d);
        chk("w1c_done", d, 32'd0);
        chk("w1c_irq", {31'b0, irq}, 32'd0);

        // LEN=4 exact sequence; START and SRC_A writes while busy must be ignored
        for (int i = 0; i < 4; i++) begin va[i] = i + 1; vb[i] = 1; end
        start_job(4);
        repeat (2) @(posedge clk);
        csr_wr(3'd0, 32'h0000_5000);
        csr_wr(3'd4, 32'd3);
        wait_done();
        chk("len4_result", mem[DA], 32'h4120_0000);
        csr_rd(3'd0, d);
        chk("busy_src_a_ignored", d, SA);

        // illegal lengths: ERR, no bus traffic
        foreach (va[i]) if (i < 2) ;
        for (int t = 0; t < 2; t++) begin
            any_req = 0;
            csr_wr(3'd3, (t == 0) ? 32'd0 : 32'd65);
            csr_wr(3'd4, 32'd3);
            repeat (4) @(posedge clk);
            csr_rd(3'd5, d);
            chk($sformatf("badlen%0d_status", t), d, 32'h4);
            chk($sformatf("badlen%0d_irq", t), {31'b0, irq}, 32'd1);
            chk($sformatf("badlen%0d_noreq", t), {31'b0, any_req}, 32'd0);
            csr_wr(3'd5, 32'd4);
            csr_rd(3'd5, d);
            chk($sformatf("badlen%0d_w1c", t), d, 32'd0);
        end

        // LEN=64 zero-wait, then with random stalls
        for (int i = 0; i < 64; i++) begin va[i] = $urandom_range(1, 7); vb[i] = $urandom_range(1, 7); end
        start_job(64);
        wait_done();
        r0 = mem[DA];
        stall_max = 5;
        start_job(64);
        wait_done();
        chk("len64_stall_vs_zero", mem[DA], r0);
        stall_max = 0;

        // reset during RDB
        for (int i = 0; i < 4; i++) begin va[i] = i + 2; vb[i] = 3; end
        start_job(4);
        chk_en = 0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end
        while (!(m_read && m_address >= SB && m_address < SB + 32'h100) && cyc < 500);
        chk("rdb_seen", {31'b0, m_read}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_m_read", {31'b0, m_read}, 32'd0);
        chk("mid_rst_m_write", {31'b0, m_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        csr_rd(3'd5, d);
        chk("mid_rst_status", d, 32'd0);
        va[0] = 3; vb[0] = 2;
        start_job(1);
        wait_done();
        chk("post_rst_result", mem[DA], 32'h40C0_0000);

        // slave holds RES: sequencer waits indefinitely
        va[0] = 5; vb[0] = 3;
        res_hold = 1;
        start_job(1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(m_read && m_address == MB) && cyc < 200);
        repeat (40) @(posedge clk);
        #1;
        chk("hold_m_read", {31'b0, m_read}, 32'd1);
        chk("hold_m_address", m_address, MB);
        csr_rd(3'd5, d);
        chk("hold_status", d, 32'd1);
        res_hold = 0;
        wait_done();
        chk("hold_result", mem[DA], 32'h4170_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_mac_dma_sequencer.md
# fpu_mac_dma_sequencer

Avalon-MM sequencer that drives the FPU MAC slave (fpu_mac_avalon_fordma) without CPU involvement. It fetches two operand vectors A and B from system memory and loads them into the MAC's operand windows. It then programs the count, starts the MAC, waits for the dot-product result and stores it to a destination address. It sits on the system interconnect with a CSR slave port for the CPU and one Avalon-MM master port that reaches both memory and the MAC slave.

## Interface
Parameters:
- MAX_LEN, 64, capacity of each MAC operand window; legal LEN is 1..MAX_LEN
- TO_W, 16, watchdog counter width (used only with the timeout feature)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- csr_address  in  3  CSR word index
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  CSR read data; combinational; 0 when csr_read is low
- m_address  out  32  master byte address
- m_read  out  1  master read request
- m_write  out  1  master write request
- m_writedata  out  32  master write data
- m_readdata  in  32  master read data; valid in the cycle the read completes
- m_waitrequest  in  1  slave stall
- irq  out  1  interrupt, level

## Operation
CSRs:
- 0 SRC_A: byte address of A.
- 1 SRC_B: byte address of B.
- 2 DST: byte address for the result.
- 3 LEN: element count.
- 4 CTRL: bit0 START (write-1 pulse), bit1 IRQ_EN.
- 5 STATUS: bit0 BUSY, bit1 DONE (W1C), bit2 ERR (W1C).
- 6 MAC_BASE: byte address of the MAC slave.
- 7 reads 0.

CSR rules:
- Writes to registers 0–3 and 6 are ignored while BUSY.
- START while BUSY is ignored.
- START clears DONE and ERR.

Bus mapping:
- MAC slave word index k maps to byte address MAC_BASE+4k.
- MAC A window: k=0..63. MAC B window: k=64..127.
- MAC control: k=128 soft reset, k=129 count, k=130 start.
- Result: read at k=0.

FSM states:
- IDLE
- CHK: if LEN==0 or LEN>MAX_LEN, set ERR and go to IDLE with no bus traffic.
- CLR: write k=128, data 0.
- RDA: read SRC_A+4i.
- WRA: write k=i with the captured A data.
- RDB: read SRC_B+4i.
- WRB: write k=64+i; then i++. If i==LEN, go to CNT; else go to RDA.
- CNT: write k=129, data LEN.
- GO: write k=130, data 1.
- RES: read k=0. The MAC holds waitrequest until its accumulation completes, so this read naturally stalls.
- STR: write DST with the captured result.
- FIN: set DONE, go to IDLE.
- The index i is 7 bits, cleared in CHK.
- Address arithmetic is 32-bit modulo 2^32, with no overflow check.
- irq = IRQ_EN & (DONE | ERR).

## Timing
- Reset values:
  - all outputs 0
  - all CSRs 0, including BUSY, DONE, ERR
  - FSM in IDLE
- The START write at edge T moves the FSM to CHK. BUSY=1 from T+1 through the FIN cycle.
- CLR drives its request from T+2.
- Master outputs are registered. Address, data and strobe stay stable while m_waitrequest=1.
- A transaction completes on the edge where m_waitrequest=0. m_readdata is captured on that edge.
- The next request is asserted in the following cycle. Exactly one of m_read or m_write is high at a time.
- With zero-wait slaves, START-to-DONE = 4·LEN + 7 cycles, plus any RES stall.
- DONE and irq assert on the edge after the STR write completes.
- Simultaneous W1C of DONE and FIN setting DONE: set wins.
- Reset mid-operation: the next edge returns the FSM to IDLE and drops m_read and m_write. The MAC is not touched; the next job's CLR resets it.

## Configuration
- FPU_SEQ_TIMEOUT_EN defined:
  - A TO_W-bit watchdog counts consecutive cycles with m_waitrequest=1 and a request active; it clears on each completion.
  - At terminal count (2^TO_W−1) the sequencer drops its strobe, sets ERR and goes to IDLE.
- FPU_SEQ_TIMEOUT_EN undefined: no watchdog; the sequencer waits indefinitely.

## Test plan
- LEN=1, A=[0x40400000], B=[0x40000000], zero-wait bus: DST receives 0x40C00000; DONE=1; irq=1 with IRQ_EN; exact 11-cycle START-to-DONE.
- LEN=4, A=[1.0,2.0,3.0,4.0], B=[1.0,1.0,1.0,1.0]: DST=0x41200000. The master transaction sequence matches the following exactly:
  - CLR
  - four RDA/WRA/RDB/WRB groups, with WRA at k=0..3 and WRB at k=64..67
  - CNT=4, GO, RES, STR
- LEN=0 and LEN=65: ERR=1; BUSY returns to 0; no m_read or m_write ever asserted.
- LEN=64 with random 0–5 cycle waitrequest stalls: the result equals the zero-wait run; master signals are stable during every stall.
- START while BUSY: ignored; SRC_A write while BUSY: ignored. Reset asserted during RDB: next cycle m_read=0, STATUS=0, IDLE; a following LEN=1 job completes correctly.
- With FPU_SEQ_TIMEOUT_EN and TO_W=4, slave holds waitrequest in RES: 15 cycles after the stall begins, m_read=0 and ERR=1. Without the macro the sequencer stays in RES.
